// File: rtl/ram_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ram_arbiter_if : requester, clear and RAM-side signals of ram_arbiter      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface ram_arbiter_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
);
   logic              req0;
   logic              req1;
   logic              we0;
   logic              we1;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic              clr_req;
   logic              ack0;
   logic              ack1;
   logic [DATA_W-1:0] rdata;
   logic              busy;
   logic [ADDR_W-1:0] ram_address;
   logic [DATA_W-1:0] ram_data_in;
   logic              ram_write_enable;
   logic              ram_reset;
   logic [DATA_W-1:0] ram_data_out;

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, clr_req, ram_data_out,
      input  ack0, ack1, rdata, busy, ram_address, ram_data_in, ram_write_enable, ram_reset
   );

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, clr_req, ram_data_out,
      output ack0, ack1, rdata, busy, ram_address, ram_data_in, ram_write_enable, ram_reset
   );
endinterface
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ram_arbiter : two-port arbiter (CPU/loader) in front of a synchronous RAM   |
// | with whole-RAM clear. Macro RAM_ARB_FIXED_PRIO_EN selects fixed priority.   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module ram_arbiter #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic         clk,
   input  logic         reset,
   ram_arbiter_if.slave bus
);
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] ACCESS = 3'd1;
   localparam logic [2:0] READ   = 3'd2;
   localparam logic [2:0] ACK    = 3'd3;
   localparam logic [2:0] CLEAR  = 3'd4;

   logic [2:0]        state, nxt_state;
   logic              gnt_id, nxt_gnt_id;
   logic              clr_pend, nxt_clr_pend;
   logic              ack0, nxt_ack0;
   logic              ack1, nxt_ack1;
   logic              busy, nxt_busy;
   logic              ram_we, nxt_ram_we;
   logic              ram_rst, nxt_ram_rst;
   logic [DATA_W-1:0] rdata, nxt_rdata;
   logic [DATA_W-1:0] ram_din, nxt_ram_din;
   logic [ADDR_W-1:0] ram_addr, nxt_ram_addr;
   logic              clr_go;
   logic              start;
   logic              winner;

   // A clear requested while busy is remembered until the next IDLE.
   assign clr_go       = bus.clr_req | clr_pend;
   assign start        = (state == IDLE) & ~clr_go & (bus.req0 | bus.req1);
   assign nxt_clr_pend = (clr_pend | bus.clr_req) & (state != IDLE);

`ifdef RAM_ARB_FIXED_PRIO_EN
   assign winner = ~bus.req0;
`else
   logic ptr, nxt_ptr;
   assign winner  = (bus.req0 & bus.req1) ? ptr : bus.req1;
   assign nxt_ptr = start ? ~winner : ptr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) ptr <= 1'b0;
      else        ptr <= nxt_ptr;
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= nxt_state;
   end

   always_comb begin
      nxt_state = state;
      case (state)
         IDLE: begin
            if (clr_go)                      nxt_state = CLEAR;
            else if (bus.req0 | bus.req1)    nxt_state = ACCESS;
         end
         ACCESS:  nxt_state = ram_we ? ACK : READ;
         READ:    nxt_state = ACK;
         ACK:     nxt_state = IDLE;
         CLEAR:   nxt_state = IDLE;
         default: nxt_state = IDLE;
      endcase
   end

   always_comb begin
      nxt_gnt_id   = gnt_id;
      nxt_rdata    = rdata;
      nxt_ram_addr = ram_addr;
      nxt_ram_din  = ram_din;
      nxt_ram_we   = 1'b0;
      nxt_ram_rst  = 1'b0;
      nxt_ack0     = 1'b0;
      nxt_ack1     = 1'b0;
      nxt_busy     = (nxt_state != IDLE);
      case (state)
         IDLE: begin
            if (clr_go) begin
               nxt_ram_rst = 1'b1;
            end else if (start) begin
               nxt_gnt_id   = winner;
               nxt_ram_addr = winner ? bus.addr1  : bus.addr0;
               nxt_ram_din  = winner ? bus.wdata1 : bus.wdata0;
               nxt_ram_we   = winner ? bus.we1    : bus.we0;
            end
         end
         ACCESS: begin
            if (ram_we) begin
               nxt_ack0 = ~gnt_id;
               nxt_ack1 = gnt_id;
            end
         end
         READ: begin
            nxt_rdata = bus.ram_data_out;
            nxt_ack0  = ~gnt_id;
            nxt_ack1  = gnt_id;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gnt_id   <= 1'b0;
         clr_pend <= 1'b0;
         ack0     <= 1'b0;
         ack1     <= 1'b0;
         busy     <= 1'b0;
         ram_we   <= 1'b0;
         ram_rst  <= 1'b0;
         rdata    <= '0;
         ram_din  <= '0;
         ram_addr <= '0;
      end else begin
         gnt_id   <= nxt_gnt_id;
         clr_pend <= nxt_clr_pend;
         ack0     <= nxt_ack0;
         ack1     <= nxt_ack1;
         busy     <= nxt_busy;
         ram_we   <= nxt_ram_we;
         ram_rst  <= nxt_ram_rst;
         rdata    <= nxt_rdata;
         ram_din  <= nxt_ram_din;
         ram_addr <= nxt_ram_addr;
      end
   end

   assign bus.ack0             = ack0;
   assign bus.ack1             = ack1;
   assign bus.busy             = busy;
   assign bus.rdata            = rdata;
   assign bus.ram_address      = ram_addr;
   assign bus.ram_data_in      = ram_din;
   assign bus.ram_write_enable = ram_we;
   assign bus.ram_reset        = ram_rst;
endmodule
`default_nettype wire
